// File: rtl/check_equal_seq.sv
// check_equal_seq: groups accepted samples into triples, reports whether all three are equal,
// and keeps triple/match statistics for the display logic.
module check_equal_seq #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_equal,
    input  logic             out_ready,
    output logic [1:0]       slot,
    output logic [CNT_W-1:0] triple_count,
    output logic [CNT_W-1:0] match_count
);
    localparam logic [1:0] LOAD0  = 2'd0;
    localparam logic [1:0] LOAD1  = 2'd1;
    localparam logic [1:0] LOAD2  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] r0, r1;

    assign slot      = state;
    assign in_ready  = state != REPORT;
    assign out_valid = state == REPORT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD0;
            r0           <= '0;
            r1           <= '0;
            out_equal    <= 1'b0;
            triple_count <= '0;
            match_count  <= '0;
        end else if (clear) begin
            state        <= LOAD0;
            triple_count <= '0;
            match_count  <= '0;
        end else if (in_valid && in_ready) begin
            if (state == LOAD0) r0 <= in_data;
            if (state == LOAD1) r1 <= in_data;
            // third sample is compared directly from the input, no r2 needed
            if (state == LOAD2) out_equal <= (r0 == r1) && (r1 == in_data);
            state <= state + 2'd1;
        end else if (out_valid && out_ready) begin
            state        <= LOAD0;
            triple_count <= triple_count + 1'b1;
            if (out_equal && match_count != '1) match_count <= match_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_check_equal_seq.sv
// tb_check_equal_seq: directed and random stimulus, scoreboard of expected triple results.
module tb_check_equal_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] in_data = '0;
    logic       in_ready, out_valid, out_equal;
    logic [1:0] slot;
    logic [7:0] triple_count, match_count;

    int total = 0;
    int passed = 0;
    bit armed = 0;

    logic [6:0] part[$];
    bit         exp_q[$];
    int         tc = 0;
    int         mc = 0;

    check_equal_seq dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_equal(out_equal), .out_ready(out_ready),
        .slot(slot), .triple_count(triple_count), .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: compare outputs mid-cycle, then apply what the next edge will do.
    always @(negedge clk) begin
        bit pend;
        pend = exp_q.size() != 0;
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(!pend));
            chk("out_valid", 32'(out_valid), 32'(pend));
            chk("slot", 32'(slot), pend ? 32'd3 : 32'(part.size()));
            chk("triple_count", 32'(triple_count), 32'(tc));
            chk("match_count", 32'(match_count), 32'(mc));
            if (pend) chk("out_equal", 32'(out_equal), 32'(exp_q[0]));
        end
        if (reset || clear) begin
            part.delete();
            exp_q.delete();
            tc = 0;
            mc = 0;
        end else if (!pend && in_valid) begin
            part.push_back(in_data);
            if (part.size() == 3) begin
                exp_q.push_back(part[0] == part[1] && part[1] == part[2]);
                part.delete();
            end
        end else if (pend && out_ready) begin
            tc = (tc + 1) % 256;
            if (exp_q[0]) mc = (mc == 255) ? 255 : mc + 1;
            void'(exp_q.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [6:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = v;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles at %0t", n, $time);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        send(a);
        send(b);
        send(c);
    endtask

    initial begin
        logic [6:0] v;
        step(2);
        reset = 1'b0;
        armed = 1;
        chk("reset_out_equal", 32'(out_equal), 32'd0);
        out_ready = 1'b1;
        send3(7'd100, 7'd100, 7'd100);
        step(2);
        send3(7'd99, 7'd99, 7'd98);
        send3(7'd98, 7'd97, 7'd97);
        step(2);
        out_ready = 1'b0;
        send3(7'd97, 7'd97, 7'd97);
        in_valid = 1'b1;
        in_data = 7'd5;
        step(5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(2);
        send(7'd42);
        step(3);
        send(7'd42);
        step(1);
        send(7'd42);
        step(2);
        send(7'd1);
        send(7'd2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(2);
        out_ready = 1'b0;
        send3(7'd7, 7'd7, 7'd7);
        clear = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        step(2);
        out_ready = 1'b0;
        send3(7'd8, 7'd8, 7'd8);
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        step(2);
        for (int i = 0; i < 256; i++) begin
            v = 7'($urandom_range(0, 127));
            send3(v, v, v);
        end
        step();
        chk("wrap_triple_count", 32'(triple_count), 32'd0);
        chk("sat_match_count", 32'(match_count), 32'd255);
        send3(7'd3, 7'd3, 7'd3);
        step();
        chk("after_wrap_triple_count", 32'(triple_count), 32'd1);
        chk("held_match_count", 32'(match_count), 32'd255);
        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            clear = $urandom_range(0, 63) == 0;
            reset = $urandom_range(0, 255) == 0;
            step();
        end
        in_valid = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        out_ready = 1'b1;
        step(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
